// File: rtl/robinson_window_gen.sv
// rtl/robinson_window_gen.sv - streaming 3x3 window generator feeding the Robinson compass kernel stage (optional in_sof via ROBINSON_WIN_SOF_EN)
module robinson_window_gen #(
    parameter int ROWS   = 242,
    parameter int COLS   = 247,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pixel,
`ifdef ROBINSON_WIN_SOF_EN
    input  logic                      in_sof,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [9*DATA_W-1:0]       out_win,
    output logic [$clog2(ROWS)-1:0]   out_row,
    output logic [$clog2(COLS)-1:0]   out_col,
    output logic                      out_last
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] CMAX = CW'(COLS - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t              state;
    logic [RW-1:0]       r;
    logic [CW-1:0]       c;

    // Two most recent rows: lb0 holds row r-2, lb1 holds row r-1
    logic [DATA_W-1:0]   lb0 [COLS];
    logic [DATA_W-1:0]   lb1 [COLS];

    // Left and middle window columns; the right column is the one arriving now.
    // Element ki of a column sits at [ki*DATA_W +: DATA_W], ki=0 on top.
    logic [3*DATA_W-1:0] col0;
    logic [3*DATA_W-1:0] col1;
    logic [3*DATA_W-1:0] new_col;
    logic [9*DATA_W-1:0] win_next;

    logic                sof;
    logic                accept;
    logic [RW-1:0]       pos_r;
    logic [CW-1:0]       pos_c;
    logic                run;
    logic                emit;

`ifdef ROBINSON_WIN_SOF_EN
    assign sof = in_sof;
`else
    assign sof = 1'b0;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel is placed at (0,0) regardless of the running counters
    assign pos_r = sof ? '0 : r;
    assign pos_c = sof ? '0 : c;
    assign run   = (state == RUN) && !sof;
    assign emit  = accept && run && (pos_c >= CW'(2));

    assign new_col = {in_pixel, lb1[pos_c], lb0[pos_c]};

    // Assemble the candidate window: element 3*ki+kj, left column oldest
    always_comb begin
        win_next = '0;
        for (int ki = 0; ki < 3; ki++) begin
            win_next[(3*ki+0)*DATA_W +: DATA_W] = col0[ki*DATA_W +: DATA_W];
            win_next[(3*ki+1)*DATA_W +: DATA_W] = col1[ki*DATA_W +: DATA_W];
            win_next[(3*ki+2)*DATA_W +: DATA_W] = new_col[ki*DATA_W +: DATA_W];
        end
    end

    // Line memories roll one row down on every accepted pixel; never reset, always overwritten before use
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[pos_c] <= lb1[pos_c];
            lb1[pos_c] <= in_pixel;
        end
    end

    // Position counters, fill/run state, column shift register and the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            r         <= '0;
            c         <= '0;
            col0      <= '0;
            col1      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            if (accept) begin
                col0 <= col1;
                col1 <= new_col;

                if (pos_c == CMAX) begin
                    c <= '0;
                    r <= (pos_r == RMAX) ? '0 : pos_r + RW'(1);
                end else begin
                    c <= pos_c + CW'(1);
                    r <= pos_r;
                end

                if (sof) begin
                    state <= FILL;
                end else if (pos_c == CMAX && pos_r == RW'(1)) begin
                    state <= RUN;
                end else if (pos_c == CMAX && pos_r == RMAX) begin
                    state <= FILL;
                end
            end

            // A new window may replace the current one only on the edge the consumer takes it
            if (emit) begin
                out_valid <= 1'b1;
                out_win   <= win_next;
                out_row   <= pos_r - RW'(1);
                out_col   <= pos_c - CW'(1);
                out_last  <= (pos_r == RMAX) && (pos_c == CMAX);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_robinson_window_gen.sv
// tb/tb_robinson_window_gen.sv - scoreboard bench for robinson_window_gen with a frame-level 3x3 extraction model
module tb_robinson_window_gen;

    localparam int ROWS   = 4;
    localparam int COLS   = 5;
    localparam int DATA_W = 8;
    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_pixel;
    logic                in_sof;
    logic                out_valid;
    logic                out_ready;
    logic [9*DATA_W-1:0] out_win;
    logic [RW-1:0]       out_row;
    logic [CW-1:0]       out_col;
    logic                out_last;

    robinson_window_gen #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
`ifdef ROBINSON_WIN_SOF_EN
        .in_sof    (in_sof),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    typedef struct {
        logic [9*DATA_W-1:0] win;
        int                  row;
        int                  col;
        bit                  last;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  img [ROWS][COLS];
    int          checks = 0;
    int          errors = 0;
    int          nwin = 0;
    bit          ready_rand = 0;
    bit          gaps = 0;
    int          stall_cnt = 0;
    bit          saw_backpressure = 0;
    logic [9*DATA_W-1:0] last_win;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [9*DATA_W-1:0] act, input logic [9*DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Consumer readiness: held high, randomised, or forced low for a stall
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else if (ready_rand) begin
                out_ready = 1'($urandom % 2);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: handshake rule, hold stability, and in-order scoreboard comparison
    initial begin
        bit                  held = 0;
        logic [9*DATA_W-1:0] h_win;
        logic [RW-1:0]       h_row;
        logic [CW-1:0]       h_col;
        logic                h_last;
        exp_t                e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                check("in_ready_rule", 72'(in_ready), 72'(!out_valid || out_ready));
                if (!in_ready) saw_backpressure = 1;
                if (held) begin
                    check("hold_valid", 72'(out_valid), 72'(1));
                    check("hold_win", out_win, h_win);
                    check("hold_pos", 72'({out_row, out_col, out_last}), 72'({h_row, h_col, h_last}));
                end
                held = 0;
                if (out_valid && !out_ready) begin
                    held = 1; h_win = out_win; h_row = out_row; h_col = out_col; h_last = out_last;
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window: got win %0h at (%0d,%0d) expected none", out_win, out_row, out_col);
                    end else begin
                        e = sbq.pop_front();
                        check("win", out_win, e.win);
                        check("row", 72'(out_row), 72'(e.row));
                        check("col", 72'(out_col), 72'(e.col));
                        check("last", 72'(out_last), 72'(e.last));
                    end
                    if (out_last) last_win = out_win;
                    nwin++;
                end
            end
        end
    end

    task automatic fill_img(input int base, input bit rnd);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                img[i][j] = rnd ? 8'($urandom) : 8'(base + 10*i + j);
    endtask

    // Every interior pixel of the frame yields one window in raster order of centre
    task automatic expect_frame();
        exp_t e;
        for (int i = 1; i < ROWS-1; i++) begin
            for (int j = 1; j < COLS-1; j++) begin
                e.win = '0;
                for (int ki = 0; ki < 3; ki++)
                    for (int kj = 0; kj < 3; kj++)
                        e.win[(3*ki+kj)*DATA_W +: DATA_W] = img[i-1+ki][j-1+kj];
                e.row  = i;
                e.col  = j;
                e.last = (i == ROWS-2) && (j == COLS-2);
                sbq.push_back(e);
            end
        end
    endtask

    task automatic send_px(input logic [7:0] p, input bit sof);
        int to = 0;
        bit done = 0;
        if (gaps) begin
            while ($urandom % 2) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            to++;
            if (!done && to > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept after %0d cycles expected accept", to);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit first_sof);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                send_px(img[i][j], first_sof && i == 0 && j == 0);
    endtask

    task automatic drain();
        int to = 0;
        while ((sbq.size() > 0 || out_valid) && to < 2000) begin
            @(posedge clk);
            #1;
            to++;
        end
        check("drain_empty", 72'(sbq.size()), 72'(0));
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 72'(in_ready), 72'(1));
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_out_last", 72'(out_last), 72'(0));
        check("rst_out_win", out_win, 72'(0));
        check("rst_out_pos", 72'({out_row, out_col}), 72'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;

        // Ordered frame, consumer always ready: latency, first/last window, count
        nwin = 0;
        fill_img(0, 0);
        expect_frame();
        for (int k = 0; k < 12; k++) send_px(img[k / COLS][k % COLS], 0);
        check("no_win_before_12", 72'(out_valid), 72'(0));
        send_px(img[2][2], 0);
        check("win_at_12_valid", 72'(out_valid), 72'(1));
        check("first_win", out_win, 72'h16_15_14_0c_0b_0a_02_01_00);
        check("first_centre", 72'({out_row, out_col}), 72'({2'd1, 3'd1}));
        for (int k = 13; k < ROWS*COLS; k++) send_px(img[k / COLS][k % COLS], 0);
        drain();
        check("count_frame1", 72'(nwin), 72'(6));
        check("last_win", last_win, 72'h22_21_20_18_17_16_0e_0d_0c);

        // Same stream with a 5-cycle consumer stall mid-frame
        nwin = 0;
        saw_backpressure = 0;
        expect_frame();
        for (int k = 0; k < 14; k++) send_px(img[k / COLS][k % COLS], 0);
        stall_cnt = 5;
        for (int k = 14; k < ROWS*COLS; k++) send_px(img[k / COLS][k % COLS], 0);
        drain();
        check("count_stall", 72'(nwin), 72'(6));
        check("in_ready_dropped", 72'(saw_backpressure), 72'(1));

        // Two back-to-back frames, second offset by 100
        nwin = 0;
        fill_img(0, 0);
        expect_frame();
        send_frame(0);
        fill_img(100, 0);
        expect_frame();
        send_frame(0);
        drain();
        check("count_b2b", 72'(nwin), 72'(12));

        // Reset after 9 pixels, then a clean frame
        nwin = 0;
        fill_img(0, 0);
        for (int k = 0; k < 9; k++) send_px(img[k / COLS][k % COLS], 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        check("no_win_before_reset", 72'(nwin), 72'(0));
        expect_frame();
        send_frame(0);
        drain();
        check("count_after_rst", 72'(nwin), 72'(6));

        // Random pixels, random input gaps and random consumer readiness
        nwin = 0;
        ready_rand = 1;
        gaps = 1;
        for (int f = 0; f < 4; f++) begin
            fill_img(0, 1);
            expect_frame();
            send_frame(0);
        end
        drain();
        check("count_random", 72'(nwin), 72'(24));

`ifdef ROBINSON_WIN_SOF_EN
        // Start-of-frame on the 8th pixel restarts positioning at that pixel
        nwin = 0;
        fill_img(0, 0);
        for (int k = 0; k < 7; k++) send_px(img[k / COLS][k % COLS], 0);
        fill_img(50, 0);
        expect_frame();
        send_frame(1);
        drain();
        check("count_sof", 72'(nwin), 72'(6));
`endif

        ready_rand = 0;
        gaps = 0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/robinson_window_gen.md
# robinson_window_gen

Streaming 3x3 window generator that sits directly upstream of the Robinson compass kernel stage. It accepts a raster-order pixel stream, one pixel per handshake, and buffers two image rows in line memories. It emits every interior 3x3 neighbourhood, together with its centre coordinates, to the downstream kernel/convolution stage. Border pixels have no full neighbourhood, produce no window, and are zero-filled by the consumer.

## Interface
- ROWS, 242, image height in pixels (>= 3)
- COLS, 247, image width in pixels (>= 3)
- DATA_W, 8, pixel width, unsigned
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_pixel  in  DATA_W  pixel, raster order (row-major, column 0 first)
- out_valid  out  1  window valid
- out_ready  in  1  consumer accepts the window
- out_win  out  9*DATA_W  window; element k = 3*ki+kj at bits [k*DATA_W +: DATA_W]; ki=0 is the top row, kj=0 is the left column
- out_row  out  $clog2(ROWS)  centre row of the window
- out_col  out  $clog2(COLS)  centre column of the window
- out_last  out  1  high with the final window of a frame

## Operation
- Counters `r`/`c` track the position of the next accepted pixel. `c` wraps at COLS-1 and increments `r`; `r` wraps at ROWS-1 to 0, which starts the next frame with no gap.
- Line memories LB0 (row r-2) and LB1 (row r-1) are each COLS×DATA_W, with combinational read at index `c`.
- On accept of pixel (r,c), i.e. `in_valid && in_ready`:
  - new column = {LB0[c], LB1[c], in_pixel}, top to bottom;
  - LB0[c] <= LB1[c]; LB1[c] <= in_pixel;
  - the 3-column shift register shifts left and loads the new column into kj=2.
- If r>=2 and c>=2, the output register loads in the same edge: the window with centre (r-1,c-1), `out_valid`=1, and `out_last` = (r==ROWS-1 && c==COLS-1).
- Otherwise no window is produced. Shift-register contents carried across a row boundary are never emitted, because c>=2 is required.
- States:
  - FILL: r<2, no output.
  - RUN: r>=2.
  - FILL→RUN on accept of (1,COLS-1).
  - RUN→FILL on accept of (ROWS-1,COLS-1).
- Windows per frame: (ROWS-2)*(COLS-2), in raster order of centre.
- Line-memory contents are not cleared at a frame start. They are overwritten before any use.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_last=0, out_win=0, out_row=0, out_col=0;
  - r=c=0, state FILL, shift register 0.
  - Line memories are not reset.
- `in_ready = !out_valid || out_ready`. This is combinational and has no skid buffer, so throughput is 1 pixel/cycle when `out_ready` is held high.
- Latency: the window appears on the outputs on the clock edge that accepts pixel (r,c), one cycle after the handshake is presented.
- `out_valid` stays high and all `out_*` fields stay stable until `out_ready` is sampled high. Then:
  - `out_valid` clears, unless the same edge accepts a new input that produces a window, in which case the new window loads.
- `in_valid` low: counters and memories hold.
- `rst` mid-frame: immediate return to reset values; the partial frame is discarded. The next accepted pixel is treated as (0,0).
- `out_ready` may toggle freely. `in_valid` may drop without losing data.

## Configuration
- ROBINSON_WIN_SOF_EN: adds input `in_sof` (1 bit).
  - When `in_sof` is high on an accepted pixel, that pixel is taken as (0,0). Counters and state resynchronise to FILL, with `r`=0 and `c`=1 after the edge.
  - A pending output window is unaffected.
- Without the macro there is no port, and position is derived purely from the pixel count.

## Test plan
- ROWS=4, COLS=5, pixel value = 10r+c, `out_ready`=1:
  - first window on accept of pixel index 12 = {0,1,2,10,11,12,20,21,22}, centre (1,1);
  - exactly 6 windows per frame;
  - last window {12,13,14,22,23,24,32,33,34}, centre (2,3), with `out_last`=1.
- Same stream with `out_ready` low for 5 cycles mid-frame:
  - `in_ready` drops while `out_valid`=1;
  - the window is held stable;
  - no window is lost or duplicated, and the sequence is identical to the first test.
- Two back-to-back frames, the second with values +100: the second frame's first window is {100,101,102,110,111,112,120,121,122}, with no stale data from frame 1.
- Assert `rst` after 9 pixels, then restart the stream: no output before the new pixel 12, and the windows match the first test.
- Random `in_valid` gaps (about 50%) with random `out_ready`: output equals a software 3x3 extraction, and `out_row`/`out_col` are correct.
- With ROBINSON_WIN_SOF_EN, `in_sof` on the 8th pixel: the subsequent stream behaves as a fresh frame starting at that pixel.
